// File: rtl/mc_mem_pkg.sv
// Shared types and constants for the multicycle core's memory responder.
// Holds the FSM state encoding, read-data source select and MMIO defaults.
package mc_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

    // Source of rdata during/after a response; ZERO covers writes and errors.
    typedef enum logic [1:0] {SEL_ZERO, SEL_RAM, SEL_MMIO} rsel_t;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;
    localparam int          WORD_BYTES        = 4;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, 32-bit words, read data registered on the enabled edge.
// Write and read share one port; rdata holds its value when not enabled.
module mem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mc_mem_responder.sv
// Memory responder for the multicycle MIPS core: word RAM, RD_LAT wait states, one MMIO register.
// Commit and RAM read both happen on the edge entering RESP; ready is a one-cycle pulse.
module mc_mem_responder
    import mc_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          RD_LAT      = 1,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [31:0] mmio_out,
    output logic        mmio_valid
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam int          OFS_W    = $clog2(WORD_BYTES);
    localparam logic [2:0]  LAT_LOAD = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    mem_state_t  state_q, state_d;
    logic [2:0]  cnt_q;
    logic [31:0] addr_q, wdata_q;
    logic        we_q;
    logic        accept, go_resp;

    logic [31:0] cur_addr, cur_wdata;
    logic        cur_we;
    logic        misaligned, hit_mmio, hit_ram, dec_err;
    logic        ram_en;
    logic [31:0] ram_rdata;

    rsel_t       sel_q;
    logic        err_q;
    logic [31:0] mmio_rd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        go_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (RD_LAT == 0) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept = (state_q == IDLE) && req;

    // With zero wait states the commit edge is the acceptance edge, so decode the live inputs.
    assign cur_addr  = (state_q == IDLE) ? addr  : addr_q;
    assign cur_we    = (state_q == IDLE) ? we    : we_q;
    assign cur_wdata = (state_q == IDLE) ? wdata : wdata_q;

    assign misaligned = (cur_addr[OFS_W-1:0] != '0);
    assign hit_mmio   = !misaligned && (cur_addr == MMIO_BASE);
    assign hit_ram    = !misaligned && !hit_mmio && (cur_addr[31:2] < 30'(DEPTH_WORDS));
    assign dec_err    = !(hit_mmio || hit_ram);

    assign ram_en = go_resp && hit_ram && !reset;

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_mem_array (
        .clk  (clk),
        .en   (ram_en),
        .we   (cur_we),
        .addr (cur_addr[2 +: AW]),
        .wdata(cur_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            cnt_q   <= LAT_LOAD;
            addr_q  <= addr;
            we_q    <= we;
            wdata_q <= wdata;
        end else if ((state_q == WAIT) && (cnt_q != 3'd0)) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q      <= SEL_ZERO;
            err_q      <= 1'b0;
            mmio_rd_q  <= '0;
            mmio_out   <= '0;
            mmio_valid <= 1'b0;
        end else if (go_resp) begin
            err_q      <= dec_err;
            mmio_rd_q  <= mmio_out;
            mmio_valid <= cur_we && hit_mmio;
            if (cur_we || dec_err) begin
                sel_q <= SEL_ZERO;
            end else if (hit_mmio) begin
                sel_q <= SEL_MMIO;
            end else begin
                sel_q <= SEL_RAM;
            end
            if (cur_we && hit_mmio) begin
                mmio_out <= cur_wdata;
            end
        end else begin
            mmio_valid <= 1'b0;
        end
    end

    assign ready = (state_q == RESP);
    assign err   = ready && err_q;

    always_comb begin
        rdata = '0;
        case (sel_q)
            SEL_RAM:  rdata = ram_rdata;
            SEL_MMIO: rdata = mmio_rd_q;
            default:  rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_mc_mem_responder.sv
// Directed bench for mc_mem_responder at RD_LAT 0, 1 and 3; a scoreboard queue per instance
// is filled at acceptance and drained by a negedge monitor that checks timing and data.
module tb_mc_mem_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    logic        req_a   [3];
    logic        we_a    [3];
    logic [31:0] addr_a  [3];
    logic [31:0] wdata_a [3];
    logic [31:0] rdata_a [3];
    logic        ready_a [3];
    logic        err_a   [3];
    logic [31:0] mmio_a  [3];
    logic        mv_a    [3];
    logic [31:0] mmio_m  [3];
    int          lat     [3] = '{0, 1, 3};

    mc_mem_responder #(.RD_LAT(0)) u_lat0 (
        .clk(clk), .reset(reset), .req(req_a[0]), .we(we_a[0]), .addr(addr_a[0]),
        .wdata(wdata_a[0]), .rdata(rdata_a[0]), .ready(ready_a[0]), .err(err_a[0]),
        .mmio_out(mmio_a[0]), .mmio_valid(mv_a[0]));

    mc_mem_responder #(.RD_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .req(req_a[1]), .we(we_a[1]), .addr(addr_a[1]),
        .wdata(wdata_a[1]), .rdata(rdata_a[1]), .ready(ready_a[1]), .err(err_a[1]),
        .mmio_out(mmio_a[1]), .mmio_valid(mv_a[1]));

    mc_mem_responder #(.RD_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset), .req(req_a[2]), .we(we_a[2]), .addr(addr_a[2]),
        .wdata(wdata_a[2]), .rdata(rdata_a[2]), .ready(ready_a[2]), .err(err_a[2]),
        .mmio_out(mmio_a[2]), .mmio_valid(mv_a[2]));

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        logic        mv;
        logic [31:0] mmio;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void push(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    task automatic monitor(input int d);
        exp_t e;
        if (!ready_a[d]) begin
            chk($sformatf("quiet_err_mv%0d", d), {30'b0, err_a[d], mv_a[d]}, 32'd0);
            return;
        end
        if (qsize(d) == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_ready%0d: got ready=1 at cycle %0d, expected no response", d, cyc);
            return;
        end
        case (d)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        chk($sformatf("ready_cycle%0d", d), 32'(cyc), 32'(e.cyc));
        chk($sformatf("rdata%0d", d), rdata_a[d], e.rdata);
        chk($sformatf("err%0d", d), {31'b0, err_a[d]}, {31'b0, e.err});
        chk($sformatf("mmio_valid%0d", d), {31'b0, mv_a[d]}, {31'b0, e.mv});
        chk($sformatf("mmio_out%0d", d), mmio_a[d], e.mmio);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 3; d++) monitor(d);
        end
    end

    task automatic wait_done(input int d);
        for (int i = 0; i < 40; i++) begin
            if (qsize(d) == 0) return;
            @(negedge clk);
        end
        n_chk++;
        n_fail++;
        $display("FAIL timeout%0d: got %0d responses outstanding, expected 0", d, qsize(d));
        case (d)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    function automatic exp_t mk(input int d, input int c, input logic [31:0] r, input logic e, input logic mv);
        exp_t x;
        x.cyc   = c + lat[d];
        x.rdata = r;
        x.err   = e;
        x.mv    = mv;
        x.mmio  = mmio_m[d];
        return x;
    endfunction

    // One isolated access: issued from IDLE, expectation pushed at the acceptance edge.
    task automatic access(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee, input logic emv);
        @(negedge clk);
        req_a[d] = 1'b1; we_a[d] = w; addr_a[d] = a; wdata_a[d] = wd;
        @(posedge clk);
        #1;
        req_a[d] = 1'b0;
        if (emv) mmio_m[d] = wd;
        push(d, mk(d, cyc, er, ee, emv));
        wait_done(d);
    endtask

    task automatic check_zero(input int d);
        chk($sformatf("rst_rdata%0d", d), rdata_a[d], 32'd0);
        chk($sformatf("rst_ready%0d", d), {31'b0, ready_a[d]}, 32'd0);
        chk($sformatf("rst_err%0d", d), {31'b0, err_a[d]}, 32'd0);
        chk($sformatf("rst_mmio_out%0d", d), mmio_a[d], 32'd0);
        chk($sformatf("rst_mmio_valid%0d", d), {31'b0, mv_a[d]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_a[d] = 1'b0; we_a[d] = 1'b0; addr_a[d] = '0; wdata_a[d] = '0; mmio_m[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 3; d++) check_zero(d);

        // RD_LAT=1: write/read round trip and RAM boundary words
        access(1, 1'b1, 32'h10,  32'h1234_5678, 32'h0, 1'b0, 1'b0);
        access(1, 1'b0, 32'h10,  32'h0, 32'h1234_5678, 1'b0, 1'b0);
        access(1, 1'b1, 32'h0,   32'h1111_1111, 32'h0, 1'b0, 1'b0);
        access(1, 1'b1, 32'h3FC, 32'h0FF0_0FF0, 32'h0, 1'b0, 1'b0);
        access(1, 1'b0, 32'h3FC, 32'h0, 32'h0FF0_0FF0, 1'b0, 1'b0);
        access(1, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1'b0);

        // RD_LAT=0: held request is accepted every other cycle
        access(0, 1'b1, 32'h0, 32'hA5A5_0001, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0] = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 0 || k == 2) push(0, mk(0, cyc, 32'hA5A5_0001, 1'b0, 1'b0));
        end
        req_a[0] = 1'b0;
        wait_done(0);

        // MMIO write/read
        access(1, 1'b1, 32'hFFFF_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
        access(1, 1'b0, 32'hFFFF_0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Errors leave RAM and MMIO untouched
        access(1, 1'b0, 32'h2,         32'h0,         32'h0, 1'b1, 1'b0);
        access(1, 1'b1, 32'h8000_0000, 32'h5555_5555, 32'h0, 1'b1, 1'b0);
        access(1, 1'b1, 32'hFFFF_0002, 32'h0000_0BAD, 32'h0, 1'b1, 1'b0);
        access(1, 1'b0, 32'h0,         32'h0, 32'h1111_1111, 1'b0, 1'b0);
        access(1, 1'b0, 32'h10,        32'h0, 32'h1234_5678, 1'b0, 1'b0);
        access(1, 1'b0, 32'hFFFF_0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // RD_LAT=3: reset during WAIT drops the pending write
        access(2, 1'b1, 32'h20, 32'hBEEF_0001, 32'h0, 1'b0, 1'b0);
        access(2, 1'b1, 32'h10, 32'h1010_1010, 32'h0, 1'b0, 1'b0);
        access(2, 1'b0, 32'h20, 32'h0, 32'hBEEF_0001, 1'b0, 1'b0);
        @(negedge clk);
        req_a[2] = 1'b1; we_a[2] = 1'b1; addr_a[2] = 32'h20; wdata_a[2] = 32'h0000_CAFE;
        @(posedge clk);
        #1;
        req_a[2] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) mmio_m[d] = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero(2);
        check_zero(1);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        access(2, 1'b0, 32'h20, 32'h0, 32'hBEEF_0001, 1'b0, 1'b0);

        // Inputs changing after acceptance are ignored
        @(negedge clk);
        req_a[2] = 1'b1; we_a[2] = 1'b0; addr_a[2] = 32'h20;
        @(posedge clk);
        #1;
        push(2, mk(2, cyc, 32'hBEEF_0001, 1'b0, 1'b0));
        addr_a[2] = 32'h10; we_a[2] = 1'b1; wdata_a[2] = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        req_a[2] = 1'b0;
        wait_done(2);
        access(2, 1'b0, 32'h10, 32'h0, 32'h1010_1010, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
